uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_sync2.sv | 24 ++
 rtl/uart_rx.sv | 138 +++++++++++++
 tb/tb_uart_rx.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and payload width.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Imported by the receiver and reusable by a transmitter.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to idle-high.
// Latency: 2 clk cycles from d to q.
// Backpressure: none.
// Ports: clk, rst (async active-low), d (async input), q (synchronized output).
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames, mid-bit sampling, single-entry holding register.
// Latency: byte appears on data_out/valid the cycle after the stop-bit sample.
// Backpressure: valid/ready; a completed byte arriving while the holding register is full and not being consumed is dropped with an overrun pulse.
// Ports: clk, rst (async active-low), in (serial line), data_out/valid/ready (byte handoff),
//        frame_err (pulse, stop bit low), overrun (pulse, byte dropped), busy (not idle).
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = uart_pkg::DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    // Tick counter counts down to zero; a sample is taken on the zero cycle.
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);

    logic                 rxs;
    uart_state_t          state;
    uart_state_t          state_nxt;
    logic [TW-1:0]        tick;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 tick_zero;
    logic                 sample_data;
    logic                 byte_done;
    logic                 stop_err;

    uart_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (in),
        .q   (rxs)
    );

    assign tick_zero = (tick == '0);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (!rxs) state_nxt = ST_START;
            // A start bit that is high again at mid-bit was a glitch.
            ST_START: if (tick_zero) state_nxt = rxs ? ST_IDLE : ST_DATA;
            ST_DATA:  if (tick_zero && (bit_cnt == LAST_DATA)) state_nxt = ST_STOP;
            // Going straight back to IDLE lets a start bit immediately after the stop bit be caught.
            ST_STOP:  if (tick_zero) state_nxt = rxs ? ST_IDLE : ST_BREAK;
            // Line must go high before a new start edge is trusted.
            ST_BREAK: if (rxs) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Output / strobe logic
    always_comb begin
        busy        = 1'b0;
        sample_data = 1'b0;
        byte_done   = 1'b0;
        stop_err    = 1'b0;
        busy        = (state != ST_IDLE);
        sample_data = (state == ST_DATA) && tick_zero;
        byte_done   = (state == ST_STOP) && tick_zero && rxs;
        stop_err    = (state == ST_STOP) && tick_zero && !rxs;
    end

    // Bit timing and shift register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick    <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    bit_cnt <= '0;
                    // Half a bit period lands the start-bit sample mid-bit.
                    tick    <= rxs ? '0 : HALF_LAST;
                end
                ST_START, ST_STOP: begin
                    tick <= tick_zero ? BIT_LAST : tick - TW'(1);
                end
                ST_DATA: begin
                    tick <= tick_zero ? BIT_LAST : tick - TW'(1);
                    if (sample_data) begin
                        shreg[bit_cnt] <= rxs;
                        bit_cnt        <= bit_cnt + BW'(1);
                    end
                end
                default: begin
                    tick <= '0;
                end
            endcase
        end
    end

    // Holding register and status pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_err;
            overrun   <= byte_done && valid && !ready;
            // A byte finishing on the same cycle the old one is taken replaces it seamlessly.
            if (byte_done && (!valid || ready)) begin
                data_out <= shreg;
                valid    <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frame scenarios plus randomized frames.
// Latency: n/a (testbench).
// Backpressure: ready is driven directly, pulsed at a computed cycle, or randomized.
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       in    = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data_out;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .data_out  (data_out),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int         tests_run    = 0;
    int         tests_failed = 0;
    int         vcnt = 0;
    int         fcnt = 0;
    int         ocnt = 0;
    logic [7:0] got[$];

    bit         rand_ready = 1'b0;
    int         pulse_at   = -10;

    int         v0, f0, o0, g0, m, nbad;
    logic [7:0] rb;
    bit         rbad;
    int         rgap;
    logic [7:0] expq[$];

    // Observe outputs mid-cycle; every handshake is recorded as a delivered byte.
    always @(negedge clk) begin
        if (rst) begin
            if (valid)          vcnt++;
            if (frame_err)      fcnt++;
            if (overrun)        ocnt++;
            if (valid && ready) got.push_back(data_out);
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (rand_ready)                ready = 1'($urandom_range(0, 1));
            else if (cyc == pulse_at)      ready = 1'b1;
            else if (cyc == pulse_at + 1)  ready = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_bits);
        in = 1'b0;
        step(CPB);
        for (int i = 0; i < 8; i++) begin
            in = b[i];
            step(CPB);
        end
        in = stop_v;
        step(CPB * stop_bits);
    endtask

    task automatic snap();
        v0 = vcnt;
        f0 = fcnt;
        o0 = ocnt;
        g0 = got.size();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got %0d cycles, expected under 100000", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step(3);
        check("rst_valid", valid, 0);
        check("rst_data", data_out, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovr", overrun, 0);
        rst = 1'b1;
        step(5);

        // Single good frame, consumer always ready
        ready = 1'b1;
        snap();
        send_frame(8'h5D, 1'b1, 1);
        step(2 * CPB);
        check("b5d_count", got.size() - g0, 1);
        check("b5d_byte", (got.size() > g0) ? got[g0] : 8'hxx, 8'h5D);
        check("b5d_valid_cycles", vcnt - v0, 1);
        check("b5d_ferr", fcnt - f0, 0);
        check("b5d_ovr", ocnt - o0, 0);

        // Short low glitch is rejected
        snap();
        in = 1'b0;
        step(4);
        in = 1'b1;
        step(2 * CPB);
        check("glitch_busy", busy, 0);
        check("glitch_valid", vcnt - v0, 0);
        check("glitch_ferr", fcnt - f0, 0);
        check("glitch_ovr", ocnt - o0, 0);

        // Stop bit low for 3 bit-times: framing error then break
        snap();
        send_frame(8'hA5, 1'b0, 3);
        check("brk_busy_low", busy, 1);
        check("brk_ferr", fcnt - f0, 1);
        in = 1'b1;
        step(4);
        check("brk_busy_high", busy, 0);
        check("brk_valid", vcnt - v0, 0);
        check("brk_ovr", ocnt - o0, 0);

        // Back-to-back frames, consumer stalled: second byte overruns
        ready = 1'b0;
        snap();
        send_frame(8'h11, 1'b1, 1);
        send_frame(8'h22, 1'b1, 1);
        step(CPB);
        check("ovr_valid", valid, 1);
        check("ovr_data", data_out, 8'h11);
        check("ovr_pulses", ocnt - o0, 1);
        check("ovr_ferr", fcnt - f0, 0);
        ready = 1'b1;
        step(1);
        ready = 1'b0;
        step(2);
        check("ovr_deliv_count", got.size() - g0, 1);
        check("ovr_deliv_byte", (got.size() > g0) ? got[g0] : 8'hxx, 8'h11);
        check("ovr_valid_clear", valid, 0);

        // Consume exactly on the completion cycle of the second frame
        snap();
        send_frame(8'h11, 1'b1, 1);
        m = cyc;
        // Frame start + 2 synchronizer cycles + half bit + 9 bit periods = stop sample cycle.
        pulse_at = m + 2 + HALF + 9 * CPB;
        send_frame(8'h22, 1'b1, 1);
        pulse_at = -10;
        check("swap_valid", valid, 1);
        check("swap_data", data_out, 8'h22);
        check("swap_ovr", ocnt - o0, 0);
        check("swap_first", (got.size() > g0) ? got[g0] : 8'hxx, 8'h11);
        ready = 1'b1;
        step(1);
        ready = 1'b0;
        step(2);
        check("swap_second", (got.size() > g0 + 1) ? got[g0 + 1] : 8'hxx, 8'h22);

        // Reset during data bit 4, then a clean frame
        ready = 1'b1;
        snap();
        in = 1'b0;
        step(CPB);
        for (int i = 0; i < 4; i++) begin
            in = 1'b1;
            step(CPB);
        end
        step(HALF);
        check("mid_busy_before", busy, 1);
        rst = 1'b0;
        #1;
        check("mid_busy_async", busy, 0);
        step(2);
        rst = 1'b1;
        step(6 * CPB);
        check("mid_no_ff", got.size() - g0, 0);
        send_frame(8'h3C, 1'b1, 1);
        step(CPB);
        check("mid_count", got.size() - g0, 1);
        check("mid_byte", (got.size() > g0) ? got[g0] : 8'hxx, 8'h3C);
        check("mid_ferr", fcnt - f0, 0);

        // Randomized frames with random gaps, some bad stop bits, random ready
        snap();
        nbad       = 0;
        rand_ready = 1'b1;
        for (int f = 0; f < 20; f++) begin
            rb   = 8'($urandom);
            rbad = ($urandom_range(0, 4) == 0) || (f == 3);
            rgap = $urandom_range(0, 2 * CPB);
            step(rgap);
            send_frame(rb, !rbad, 1);
            if (rbad) begin
                in = 1'b1;
                step(CPB);
                nbad++;
            end else begin
                expq.push_back(rb);
            end
        end
        step(3 * CPB);
        rand_ready = 1'b0;
        ready      = 1'b1;
        step(2);
        ready      = 1'b0;
        step(2);
        check("rnd_count", got.size() - g0, expq.size());
        for (int i = 0; i < expq.size(); i++) begin
            check($sformatf("rnd_byte%0d", i),
                  (got.size() > g0 + i) ? got[g0 + i] : 8'hxx, expq[i]);
        end
        check("rnd_ferr", fcnt - f0, nbad);
        check("rnd_ovr", ocnt - o0, 0);
        check("rnd_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
